// File: rtl/mem_rr_arbiter_if.sv
// Requester-side and memory-side generic bus bundle for mem_rr_arbiter.
// slave = arbiter view, master = environment (requesters + memory controller) view.
interface mem_rr_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]    req_ren;
  logic [NREQ-1:0]    req_wen;
  logic [NREQ*32-1:0] req_addr;
  logic [NREQ*32-1:0] req_wdata;
  logic [NREQ*4-1:0]  req_byte_en;
  logic [NREQ-1:0]    req_busy;
  logic [NREQ*32-1:0] req_rdata;
  logic               mem_ren;
  logic               mem_wen;
  logic [31:0]        mem_addr;
  logic [31:0]        mem_wdata;
  logic [3:0]         mem_byte_en;
  logic               mem_busy;
  logic [31:0]        mem_rdata;
  logic [NREQ-1:0]    gnt;

  modport slave (
    input  req_ren, req_wen, req_addr, req_wdata, req_byte_en, mem_busy, mem_rdata,
    output req_busy, req_rdata, mem_ren, mem_wen, mem_addr, mem_wdata, mem_byte_en, gnt
  );

  modport master (
    output req_ren, req_wen, req_addr, req_wdata, req_byte_en, mem_busy, mem_rdata,
    input  req_busy, req_rdata, mem_ren, mem_wen, mem_addr, mem_wdata, mem_byte_en, gnt
  );
endinterface

// File: rtl/mem_rr_arbiter.sv
// N-requester arbiter for one memory bus: port-0 priority, starvation override, round-robin.
// Zero-latency combinational pass-through; grant held until mem_busy drops, others see busy=1.
module mem_rr_arbiter #(
  parameter int NREQ         = 4,
  parameter int PRIO0        = 1,
  parameter int STARVE_LIMIT = 15
) (
  input  logic            CLK,
  input  logic            RST,
  mem_rr_arbiter_if.slave bus
);
  localparam int         IW        = $clog2(NREQ);
  localparam logic [7:0] STARVE_TH = 8'(STARVE_LIMIT);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t             state, state_nxt;
  logic [IW-1:0]      lock_idx, lock_idx_nxt;
  logic [IW-1:0]      rr_ptr, rr_ptr_nxt;
  logic [7:0]         wait_cnt [NREQ];
  logic [NREQ-1:0]    req;
  logic [IW-1:0]      win_idx, starve_idx, rr_idx, scan_idx, gnt_idx;
  logic               starve_vld, gnt_vld, done;

  logic [NREQ-1:0]    gnt_c, busy_c;
  logic [NREQ*32-1:0] rdata_c;
  logic               mren_c, mwen_c;
  logic [31:0]        maddr_c, mwdata_c;
  logic [3:0]         mbe_c;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
    return (int'(i) == NREQ - 1) ? '0 : i + 1'b1;
  endfunction

  assign req = bus.req_ren | bus.req_wen;

  always_comb begin : pick
    starve_vld = 1'b0;
    starve_idx = '0;
    rr_idx     = rr_ptr;
    scan_idx   = '0;
    // Scan from the top down so the lowest qualifying index is the last one written.
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i] && wait_cnt[i] >= STARVE_TH) begin
        starve_vld = 1'b1;
        starve_idx = IW'(i);
      end
    end
    for (int k = NREQ - 1; k >= 0; k--) begin
      scan_idx = IW'((int'(rr_ptr) + k) % NREQ);
      if (req[scan_idx]) rr_idx = scan_idx;
    end
    if (PRIO0 != 0 && req[0]) win_idx = '0;
    else if (starve_vld)      win_idx = starve_idx;
    else                      win_idx = rr_idx;
  end

  always_comb begin : fsm
    state_nxt    = state;
    lock_idx_nxt = lock_idx;
    rr_ptr_nxt   = rr_ptr;
    gnt_vld      = 1'b0;
    gnt_idx      = lock_idx;
    done         = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          gnt_vld = 1'b1;
          gnt_idx = win_idx;
          if (!bus.mem_busy) begin
            done       = 1'b1;
            rr_ptr_nxt = wrap_inc(win_idx);
          end else begin
            state_nxt    = LOCKED;
            lock_idx_nxt = win_idx;
          end
        end
      end
      LOCKED: begin
        gnt_vld = 1'b1;
        // A dropped request is an abort: nothing moved, so the pointer stays put.
        if (!req[lock_idx]) begin
          state_nxt = IDLE;
        end else if (!bus.mem_busy) begin
          done       = 1'b1;
          state_nxt  = IDLE;
          rr_ptr_nxt = wrap_inc(lock_idx);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin : route
    gnt_c    = '0;
    busy_c   = '1;
    rdata_c  = '0;
    mren_c   = 1'b0;
    mwen_c   = 1'b0;
    maddr_c  = '0;
    mwdata_c = '0;
    mbe_c    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_vld && gnt_idx == IW'(i)) begin
        gnt_c[i]             = 1'b1;
        mren_c               = bus.req_ren[i];
        mwen_c               = bus.req_wen[i];
        maddr_c              = bus.req_addr[32*i +: 32];
        mwdata_c             = bus.req_wdata[32*i +: 32];
        mbe_c                = bus.req_byte_en[4*i +: 4];
        busy_c[i]            = bus.mem_busy;
        rdata_c[32*i +: 32]  = bus.mem_rdata;
      end
    end
  end

  assign bus.gnt         = gnt_c;
  assign bus.req_busy    = busy_c;
  assign bus.req_rdata   = rdata_c;
  assign bus.mem_ren     = mren_c;
  assign bus.mem_wen     = mwen_c;
  assign bus.mem_addr    = maddr_c;
  assign bus.mem_wdata   = mwdata_c;
  assign bus.mem_byte_en = mbe_c;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      lock_idx <= '0;
      rr_ptr   <= '0;
      for (int i = 0; i < NREQ; i++) wait_cnt[i] <= '0;
    end else begin
      state    <= state_nxt;
      lock_idx <= lock_idx_nxt;
      rr_ptr   <= rr_ptr_nxt;
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] || (done && gnt_idx == IW'(i))) wait_cnt[i] <= '0;
        else if (wait_cnt[i] != 8'hFF)              wait_cnt[i] <= wait_cnt[i] + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Three arbiter configurations share one stimulus stream; each is checked every cycle
// against a transaction-level model of the arbitration rules, plus directed literal checks.
module tb_mem_rr_arbiter;
  localparam int N  = 4;
  localparam int ND = 3;
  localparam int P_PRIO   [ND] = '{1, 0, 0};
  localparam int P_STARVE [ND] = '{15, 15, 4};

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic [3:0]   s_ren, s_wen;
  logic [127:0] s_addr, s_wdata;
  logic [15:0]  s_be;
  logic         s_busy;
  logic [31:0]  s_rdata;

  mem_rr_arbiter_if #(.NREQ(N)) bus0 ();
  mem_rr_arbiter_if #(.NREQ(N)) bus1 ();
  mem_rr_arbiter_if #(.NREQ(N)) bus2 ();

  mem_rr_arbiter #(.NREQ(N), .PRIO0(1), .STARVE_LIMIT(15)) dut0 (.CLK(CLK), .RST(RST), .bus(bus0));
  mem_rr_arbiter #(.NREQ(N), .PRIO0(0), .STARVE_LIMIT(15)) dut1 (.CLK(CLK), .RST(RST), .bus(bus1));
  mem_rr_arbiter #(.NREQ(N), .PRIO0(0), .STARVE_LIMIT(4))  dut2 (.CLK(CLK), .RST(RST), .bus(bus2));

  assign {bus0.req_ren, bus0.req_wen, bus0.req_addr, bus0.req_wdata, bus0.req_byte_en, bus0.mem_busy, bus0.mem_rdata}
         = {s_ren, s_wen, s_addr, s_wdata, s_be, s_busy, s_rdata};
  assign {bus1.req_ren, bus1.req_wen, bus1.req_addr, bus1.req_wdata, bus1.req_byte_en, bus1.mem_busy, bus1.mem_rdata}
         = {s_ren, s_wen, s_addr, s_wdata, s_be, s_busy, s_rdata};
  assign {bus2.req_ren, bus2.req_wen, bus2.req_addr, bus2.req_wdata, bus2.req_byte_en, bus2.mem_busy, bus2.mem_rdata}
         = {s_ren, s_wen, s_addr, s_wdata, s_be, s_busy, s_rdata};

  // {gnt, mem_ren, mem_wen, mem_addr, mem_wdata, mem_byte_en, req_busy, req_rdata}
  wire [205:0] o_all [ND];
  assign o_all[0] = {bus0.gnt, bus0.mem_ren, bus0.mem_wen, bus0.mem_addr, bus0.mem_wdata, bus0.mem_byte_en, bus0.req_busy, bus0.req_rdata};
  assign o_all[1] = {bus1.gnt, bus1.mem_ren, bus1.mem_wen, bus1.mem_addr, bus1.mem_wdata, bus1.mem_byte_en, bus1.req_busy, bus1.req_rdata};
  assign o_all[2] = {bus2.gnt, bus2.mem_ren, bus2.mem_wen, bus2.mem_addr, bus2.mem_wdata, bus2.mem_byte_en, bus2.req_busy, bus2.req_rdata};

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the bus, where round-robin resumes, how long each port waited.
  bit m_valid = 1'b0;
  bit m_owned [ND];
  int m_owner [ND];
  int m_rr    [ND];
  int m_wait  [ND][N];

  function automatic int m_win(input int d);
    logic [3:0] r;
    r = s_ren | s_wen;
    if (m_owned[d]) return m_owner[d];
    if (r == 4'b0) return -1;
    if (P_PRIO[d] != 0 && r[0]) return 0;
    for (int i = 0; i < N; i++) if (r[i] && m_wait[d][i] >= P_STARVE[d]) return i;
    for (int k = 0; k < N; k++) if (r[(m_rr[d] + k) % N]) return (m_rr[d] + k) % N;
    return -1;
  endfunction

  function automatic logic [205:0] m_expect(input int d);
    int g;
    logic [3:0]   e_gnt, e_busy, e_be;
    logic         e_ren, e_wen;
    logic [31:0]  e_addr, e_wdata;
    logic [127:0] e_rd;
    g = m_win(d);
    e_gnt = '0; e_busy = 4'hF; e_be = '0; e_ren = 1'b0; e_wen = 1'b0;
    e_addr = '0; e_wdata = '0; e_rd = '0;
    if (g >= 0) begin
      e_gnt[g]         = 1'b1;
      e_ren            = s_ren[g];
      e_wen            = s_wen[g];
      e_addr           = s_addr[32*g +: 32];
      e_wdata          = s_wdata[32*g +: 32];
      e_be             = s_be[4*g +: 4];
      e_busy[g]        = s_busy;
      e_rd[32*g +: 32] = s_rdata;
    end
    return {e_gnt, e_ren, e_wen, e_addr, e_wdata, e_be, e_busy, e_rd};
  endfunction

  task automatic model_step();
    logic [3:0] r;
    int g;
    bit fin;
    r = s_ren | s_wen;
    for (int d = 0; d < ND; d++) begin
      if (RST) begin
        m_owned[d] = 1'b0; m_owner[d] = 0; m_rr[d] = 0;
        for (int i = 0; i < N; i++) m_wait[d][i] = 0;
      end else if (m_valid) begin
        g   = m_win(d);
        fin = (g >= 0) && r[g] && !s_busy;
        for (int i = 0; i < N; i++)
          m_wait[d][i] = (!r[i] || (fin && i == g)) ? 0 : ((m_wait[d][i] < 255) ? m_wait[d][i] + 1 : 255);
        if (fin) begin
          m_owned[d] = 1'b0;
          m_rr[d]    = (g + 1) % N;
        end else if (m_owned[d]) begin
          if (!r[m_owner[d]]) m_owned[d] = 1'b0;
        end else if (g >= 0) begin
          m_owned[d] = 1'b1;
          m_owner[d] = g;
        end
      end
    end
    if (RST) m_valid = 1'b1;
  endtask

  initial forever begin
    @(posedge CLK);
    model_step();
  end

  initial forever begin
    @(negedge CLK);
    if (m_valid) begin
      for (int d = 0; d < ND; d++) begin
        checks++;
        if (o_all[d] !== m_expect(d)) begin
          errors++;
          $display("FAIL dut%0d outputs got %h want %h", d, o_all[d], m_expect(d));
        end
      end
    end
  end

  function automatic logic [3:0] gnt_of(input int d);
    return o_all[d][205:202];
  endfunction
  function automatic logic [3:0] busy_of(input int d);
    return o_all[d][131:128];
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  // Drive one cycle of inputs just after the edge; a locked owner that drops its request
  // is always paired with mem_busy=1 so the cycle is an unambiguous abort.
  task automatic apply(input logic rst, input logic [3:0] ren, input logic [3:0] wen,
                       input logic busy, input logic [31:0] rdata);
    logic [3:0] r;
    @(posedge CLK);
    #1;
    RST = rst; s_ren = ren; s_wen = wen; s_busy = busy; s_rdata = rdata;
    for (int p = 0; p < N; p++) begin
      s_addr[32*p +: 32]  = $urandom;
      s_wdata[32*p +: 32] = $urandom;
      s_be[4*p +: 4]      = 4'($urandom);
    end
    r = ren | wen;
    for (int d = 0; d < ND; d++) if (m_owned[d] && !r[m_owner[d]]) s_busy = 1'b1;
    #1;
  endtask

  task automatic do_reset();
    apply(1'b1, 4'h0, 4'h0, 1'b1, 32'h0);
  endtask

  logic [3:0] act;
  logic [1:0] kind [N];
  logic [3:0] exp_g;

  initial begin
    s_ren = '0; s_wen = '0; s_addr = '0; s_wdata = '0; s_be = '0; s_busy = 1'b0; s_rdata = '0;
    act = '0;
    for (int p = 0; p < N; p++) kind[p] = 2'd1;

    do_reset();
    apply(1'b0, 4'h0, 4'h0, 1'b0, 32'h0);
    chk("reset gnt", gnt_of(1), 4'h0);
    chk("reset req_busy", busy_of(1), 4'hF);
    chk("reset mem_ren", o_all[1][201], 1'b0);

    // Single port-2 read, three busy cycles then completion.
    for (int c = 0; c < 4; c++) begin
      apply(1'b0, 4'b0100, 4'h0, (c < 3), 32'hDEADBEEF);
      chk("p2 read gnt", gnt_of(0), 4'b0100);
    end
    chk("p2 rdata slot2", o_all[0][95:64], 32'hDEADBEEF);
    chk("p2 done busy", busy_of(0), 4'b1011);
    apply(1'b0, 4'b1010, 4'h0, 1'b1, 32'h0);
    chk("rr_ptr=3 picks p3", gnt_of(1), 4'b1000);
    apply(1'b0, 4'b1010, 4'h0, 1'b0, 32'h0);

    // All four requesting, two-cycle transfers, no port-0 priority.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      exp_g = '0;
      exp_g[k % N] = 1'b1;
      apply(1'b0, 4'hF, 4'h0, 1'b1, 32'h0);
      chk("rr order", gnt_of(1), exp_g);
      apply(1'b0, 4'hF, 4'h0, 1'b0, $urandom);
      chk("rr hold", gnt_of(1), exp_g);
    end

    // Lock on port 1; port 0 arrives mid-transfer and must wait.
    do_reset();
    apply(1'b0, 4'b0010, 4'h0, 1'b1, 32'h0);
    apply(1'b0, 4'b0011, 4'h0, 1'b1, 32'h0);
    chk("lock ignores prio", gnt_of(0), 4'b0010);
    apply(1'b0, 4'b0011, 4'h0, 1'b0, 32'h0);
    chk("lock completes", gnt_of(0), 4'b0010);
    apply(1'b0, 4'b0001, 4'h0, 1'b1, 32'h0);
    chk("prio after lock", gnt_of(0), 4'b0001);

    // Port 3 starves behind a long port-1 transfer.
    do_reset();
    for (int c = 0; c < 5; c++) apply(1'b0, 4'b1010, 4'h0, 1'b1, 32'h0);
    apply(1'b0, 4'b1110, 4'h0, 1'b0, 32'h0);
    apply(1'b0, 4'b1110, 4'h0, 1'b1, 32'h0);
    chk("starved p3 wins", gnt_of(2), 4'b1000);
    chk("no starve rr p2", gnt_of(1), 4'b0100);

    // Abort of a locked port-2 read.
    do_reset();
    apply(1'b0, 4'b0100, 4'h0, 1'b1, 32'h0);
    apply(1'b0, 4'b0000, 4'h0, 1'b1, 32'h0);
    chk("abort mem_ren", o_all[1][201], 1'b0);
    chk("abort gnt held", gnt_of(1), 4'b0100);
    apply(1'b0, 4'b1010, 4'h0, 1'b1, 32'h0);
    chk("abort rr unchanged", gnt_of(1), 4'b0010);

    // Reset while locked on port 1 with rr_ptr moved to 3.
    do_reset();
    apply(1'b0, 4'b0100, 4'h0, 1'b0, 32'h0);
    apply(1'b0, 4'b0010, 4'h0, 1'b1, 32'h0);
    chk("pre-reset lock", gnt_of(1), 4'b0010);
    do_reset();
    apply(1'b0, 4'h0, 4'h0, 1'b0, 32'h0);
    chk("post-reset gnt", gnt_of(1), 4'h0);
    chk("post-reset mem_rw", o_all[1][201:200], 2'b00);
    chk("post-reset busy", busy_of(1), 4'hF);
    apply(1'b0, 4'b1010, 4'h0, 1'b1, 32'h0);
    chk("post-reset rr=0", gnt_of(1), 4'b0010);

    // Random traffic with sticky requests and occasional resets.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      for (int p = 0; p < N; p++) begin
        if ($urandom_range(5) == 0) begin
          act[p] = ~act[p];
          if (act[p]) kind[p] = 2'($urandom_range(3, 1));
        end
      end
      apply(($urandom_range(499) == 0),
            act & {kind[3][0], kind[2][0], kind[1][0], kind[0][0]},
            act & {kind[3][1], kind[2][1], kind[1][1], kind[0][1]},
            ($urandom_range(2) != 0), $urandom);
    end
    apply(1'b0, 4'h0, 4'h0, 1'b1, 32'h0);
    @(posedge CLK);
    #2;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
